rr_arb4: RTL and testbench
==========================

Name: rr_arb4

Overview:
- Round-robin arbiter sharing one 4-input shared resource among four requesters, e.g. the memory/bus port fed through a 4:1 data mux.
- Registers a one-hot grant and the matching 2-bit mux select, and holds ownership until the transaction ends.
- Sits between the requesters (fetch, load/store, debug, DMA) and the shared-resource mux select input.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may hold the grant; used only when ARB_TIMEOUT_EN is defined; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- req  input  4  request per requester; held high until granted and finished.
- done  input  1  shared resource signals that the current owner's transaction completes this cycle.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  binary index of the owner, registered; drives the 4:1 data mux select.
- busy  output  1  high while any grant is active.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: gnt=4'b0000, sel=2'b00, busy=0, priority pointer ptr=2'd0, state=IDLE.
- States: IDLE, BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set bit of req, scanning circularly from ptr upward (ptr, ptr+1, ... mod 4).
  - Next cycle: gnt=onehot(w), sel=w, busy=1, state=BUSY, ptr=w+1 mod 4.
  - Latency from req to gnt is 1 cycle.
- BUSY, release condition: done==1, or req[sel]==0 (owner withdrew).
- BUSY, no release: gnt, sel and ptr hold.
- BUSY, release with other requests pending:
  - Arbitration runs in the release cycle over req with the owner bit masked.
  - New grant appears next cycle, with no idle gap. ptr is updated as above.
- BUSY, release with no other request: next cycle gnt=0, busy=0, state=IDLE. sel keeps its last value.
- Re-grant to the same owner: the owner bit is masked only in the release cycle, so the same owner can be granted again on a later cycle only.
- Pointer wrap: ptr=3 with a win at 3 gives ptr=0.
- Simultaneous done and a new req on the owner's line: the owner is still masked that cycle.
- Invariants:
  - gnt is always zero or one-hot.
  - sel equals the index of gnt whenever busy=1.
  - A request asserted while others are served waits at most 3 grants.
- reset has priority over every other event, including mid-transaction; the grant drops on the next edge.
- req bits that deassert before being granted are simply dropped; no queuing.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on each new grant and increments every BUSY cycle.
  - When the counter reaches MAX_HOLD-1 without done, release is forced as if done=1, and a 1-cycle pulse is asserted on extra output timeout (1 bit, reset 0).
  - The forced owner is masked from that cycle's arbitration.
- Undefined: no counter and no timeout port; an owner may hold indefinitely.

Decomposition:
- Package rr_arb4_pkg:
  - State encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1.
  - NUM_REQ=4.
  - SEL_W=2.
- Sub-module rr_pick4 (combinational):
  - Inputs: 4-bit masked request vector and 2-bit ptr.
  - Outputs: found and 2-bit winner index.
  - Instantiated once inside rr_arb4.

Test Plan:
- Reset, then req=4'b0101 with ptr=0: gnt=4'b0001, sel=0 one cycle later. done pulse gives gnt=4'b0100, sel=2 next cycle, busy stays 1.
- req=4'b1111 held, done pulsed every 2 cycles: grant order 0,1,2,3,0; sel tracks gnt; no idle cycle between grants.
- Owner 2 drops req without done, others idle: next cycle gnt=0, busy=0, sel stays 2. A later req=4'b0100 is granted after 1 cycle.
- reset asserted while owner 1 is BUSY: next edge gnt=0, sel=0, busy=0, ptr=0. With req=4'b0010 held, the grant returns one cycle after reset deasserts.
- ptr=3, req=4'b1001: winner 3, then ptr wraps to 0. After done, winner 0.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011, done never asserted: owner 0 force-released after 4 BUSY cycles; timeout pulses 1 cycle; gnt=4'b0010 next cycle.

Source files
------------

// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the rr_arb4 round-robin arbiter.
// Optional hold timeout is enabled in rr_arb4 with ARB_TIMEOUT_EN.
package rr_arb4_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Circular first-set-bit picker: scans req starting at ptr, wrapping mod 4.
module rr_pick4
    import rr_arb4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   win
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [SEL_W-1:0]     off_s;

    // Rotate so that bit 0 of rot_s is the request at ptr.
    assign dbl_s = {req, req};
    assign rot_s = dbl_s[{1'b0, ptr} +: NUM_REQ];

    // Priority encode the rotated vector; offset is relative to ptr.
    always_comb begin
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
    end

    assign found = |req;
    assign win   = ptr + off_s;

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with registered one-hot grant and mux select.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD busy cycles.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    state_t             state_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [SEL_W-1:0]   sel_r;
    logic               busy_r;
    logic [SEL_W-1:0]   ptr_r;

    logic [NUM_REQ-1:0] mask_s;
    logic               found_s;
    logic [SEL_W-1:0]   win_s;
    logic               rel_s;
    logic               grant_s;
    logic               tmo_hit_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] cnt_r;
    logic             timeout_r;

    // Force a release once the owner has held for MAX_HOLD busy cycles.
    always_comb begin
        tmo_hit_s = 1'b0;
        if (state_r == ST_BUSY && cnt_r == CNT_W'(MAX_HOLD - 1) && !done) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Hold counter and one-cycle timeout pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= tmo_hit_s;
            if (grant_s) begin
                cnt_r <= '0;
            end else if (state_r == ST_BUSY) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign timeout = timeout_r;
`else
    logic unused_s;

    assign tmo_hit_s = 1'b0;
    assign unused_s  = ^MAX_HOLD;
`endif

    // The current owner is excluded from the arbitration of its release cycle.
    always_comb begin
        mask_s = req;
        case (state_r)
            ST_IDLE: mask_s = req;
            ST_BUSY: mask_s = req & ~gnt_r;
            default: mask_s = req;
        endcase
    end

    // Release on done, owner withdrawal, or forced timeout.
    always_comb begin
        rel_s = 1'b0;
        if (state_r == ST_BUSY) begin
            rel_s = done | ~req[sel_r] | tmo_hit_s;
        end else begin
            rel_s = 1'b0;
        end
    end

    assign grant_s = found_s & ((state_r == ST_IDLE) | rel_s);

    rr_pick4 u_pick (
        .req   (mask_s),
        .ptr   (ptr_r),
        .found (found_s),
        .win   (win_s)
    );

    // Arbitration FSM; a release with pending requests hands over with no idle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            busy_r  <= 1'b0;
            ptr_r   <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_BUSY: begin
                    if (grant_s) begin
                        state_r <= ST_BUSY;
                        gnt_r   <= onehot4(win_s);
                        sel_r   <= win_s;
                        busy_r  <= 1'b1;
                        ptr_r   <= win_s + 2'd1;
                    end else if (rel_s) begin
                        state_r <= ST_IDLE;
                        gnt_r   <= 4'b0000;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 4'b0000;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = gnt_r;
    assign sel  = sel_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_rr_arb4.sv
// Directed self-checking bench for rr_arb4; covers the timeout path when
// ARB_TIMEOUT_EN is defined, otherwise checks that a grant is held indefinitely.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    rr_arb4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic b);
        check_eq({tag, "/gnt"}, gnt, g);
        check_eq({tag, "/sel"}, {2'b00, sel}, {2'b00, s});
        check_eq({tag, "/busy"}, {3'b000, busy}, {3'b000, b});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [1:0] w;

        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        step(2);
        expect_out("reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;

        // ptr=0, req 0101 -> owner 0, then done hands over to 2
        req = 4'b0101;
        step(1);
        expect_out("first", 4'b0001, 2'd0, 1'b1);
        done = 1'b1;
        step(1);
        expect_out("handover", 4'b0100, 2'd2, 1'b1);
        req = 4'b0100;
        step(1);
        expect_out("to_idle", 4'b0000, 2'd2, 1'b0);
        // ptr=3 now: winner 3, then wrap to 0
        done = 1'b0;
        req  = 4'b1001;
        step(1);
        expect_out("wrap3", 4'b1000, 2'd3, 1'b1);
        done = 1'b1;
        step(1);
        expect_out("wrap0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0001;
        step(1);
        expect_out("wrap_idle", 4'b0000, 2'd0, 1'b0);
        done = 1'b0;
        req  = 4'b0000;

        // All requesting, done every second cycle: 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        step(1);
        for (int k = 0; k < 5; k++) begin
            w = order[k][1:0];
            expect_out("rr_a", 4'b0001 << w, w, 1'b1);
            step(1);
            expect_out("rr_b", 4'b0001 << w, w, 1'b1);
            done = 1'b1;
            step(1);
            done = 1'b0;
        end
        expect_out("rr_next", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        step(1);
        expect_out("rr_idle", 4'b0000, 2'd1, 1'b0);

        // Owner 2 withdraws without done
        do_reset();
        req = 4'b0100;
        step(1);
        expect_out("own2", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        step(1);
        expect_out("withdraw", 4'b0000, 2'd2, 1'b0);
        req = 4'b0100;
        step(1);
        expect_out("regrant2", 4'b0100, 2'd2, 1'b1);

        // Withdraw while another waits: direct handover to 1
        req = 4'b0010;
        step(1);
        expect_out("own1", 4'b0010, 2'd1, 1'b1);
        reset = 1'b1;
        step(1);
        expect_out("mid_reset", 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;
        step(1);
        expect_out("post_reset", 4'b0010, 2'd1, 1'b1);

        // done with owner still requesting: masked this cycle, regranted later
        done = 1'b1;
        step(1);
        expect_out("mask_same", 4'b0000, 2'd1, 1'b0);
        done = 1'b0;
        step(1);
        expect_out("later_same", 4'b0010, 2'd1, 1'b1);
        req = 4'b0000;
        step(1);

        // Owner never signals done
        do_reset();
        req = 4'b0011;
        step(1);
        expect_out("hold0", 4'b0001, 2'd0, 1'b1);
`ifdef ARB_TIMEOUT_EN
        check_eq("tmo_low0", {3'b000, timeout}, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step(1);
            expect_out("tmo_hold", 4'b0001, 2'd0, 1'b1);
            check_eq("tmo_low", {3'b000, timeout}, 4'b0000);
        end
        step(1);
        expect_out("tmo_hand", 4'b0010, 2'd1, 1'b1);
        check_eq("tmo_pulse", {3'b000, timeout}, 4'b0001);
        step(1);
        expect_out("tmo_after", 4'b0010, 2'd1, 1'b1);
        check_eq("tmo_clear", {3'b000, timeout}, 4'b0000);
`else
        step(20);
        expect_out("hold_long", 4'b0001, 2'd0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
